// File: rtl/lock_pid_supervisor_if.sv
// Signal bundle between the PID lock supervisor and its environment (PID block, control registers).
// The slave modport is the supervisor's view; master is the driver/observer side.
interface lock_pid_supervisor_if #(
  parameter int CW = 16,
  parameter int LW = 8
);
  logic                 enable_i;
  logic                 relock_i;
  logic signed [14:0]   err_i;
  logic signed [13:0]   pid_out_i;
  logic        [13:0]   err_thr_i;
  logic        [12:0]   out_lim_i;
  logic        [CW-1:0] hold_cnt_i;
  logic        [CW-1:0] lock_cnt_i;
  logic        [CW-1:0] unlock_cnt_i;
  logic                 int_rst_o;
  logic                 pid_freeze_o;
  logic                 pid_ifreeze_o;
  logic                 locked_o;
  logic        [2:0]    state_o;
  logic        [LW-1:0] lost_cnt_o;

  modport slave (
    input  enable_i, relock_i, err_i, pid_out_i, err_thr_i, out_lim_i,
           hold_cnt_i, lock_cnt_i, unlock_cnt_i,
    output int_rst_o, pid_freeze_o, pid_ifreeze_o, locked_o, state_o, lost_cnt_o
  );

  modport master (
    output enable_i, relock_i, err_i, pid_out_i, err_thr_i, out_lim_i,
           hold_cnt_i, lock_cnt_i, unlock_cnt_i,
    input  int_rst_o, pid_freeze_o, pid_ifreeze_o, locked_o, state_o, lost_cnt_o
  );
endinterface

// File: rtl/lock_pid_supervisor.sv
// Lock supervisor for a PID loop: sequences integrator reset, acquisition, lock monitoring
// and hold, and counts lock-loss events. Outputs decode only from registered state.
//
// state   | meaning
// IDLE    | disabled, integrator held in reset
// RESET   | integrator reset for hold_cnt cycles
// ACQUIRE | waiting for lock_cnt in-window cycles; abort on unlock_cnt saturated cycles
// LOCKED  | lock declared; unlock_cnt bad cycles end it
// HOLD    | lock lost without relock, PID frozen until disabled
module lock_pid_supervisor #(
  parameter int CW = 16,
  parameter int LW = 8
) (
  input logic                  clk_i,
  input logic                  rstn_i,
  lock_pid_supervisor_if.slave sup
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RESET   = 3'd1;
  localparam logic [2:0] ST_ACQUIRE = 3'd2;
  localparam logic [2:0] ST_LOCKED  = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] run_q, run_d;
  logic [CW-1:0] sat_q, sat_d;
  logic [LW-1:0] lost_q, lost_d;

  logic [14:0]   err_u, err_abs;
  logic [13:0]   out_u, out_abs;
  logic          in_win, out_sat, bad;
  logic [CW-1:0] hold_n, lock_n, unlock_n;
  logic [3:0]    dec;

  function automatic logic reached(input logic [CW-1:0] cnt, input logic [CW-1:0] thr);
    return ({1'b0, cnt} + (CW+1)'(1)) >= {1'b0, thr};
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt);
    return (&cnt) ? cnt : cnt + CW'(1);
  endfunction

  // Two's-complement magnitude kept at full input width so the most negative code is exact.
  always_comb begin
    err_u    = sup.err_i;
    out_u    = sup.pid_out_i;
    err_abs  = err_u[14] ? (~err_u + 15'd1) : err_u;
    out_abs  = out_u[13] ? (~out_u + 14'd1) : out_u;
    in_win   = err_abs <= {1'b0, sup.err_thr_i};
    out_sat  = out_abs >= {1'b0, sup.out_lim_i};
    bad      = !in_win || out_sat;
    hold_n   = (sup.hold_cnt_i   == '0) ? CW'(1) : sup.hold_cnt_i;
    lock_n   = (sup.lock_cnt_i   == '0) ? CW'(1) : sup.lock_cnt_i;
    unlock_n = (sup.unlock_cnt_i == '0) ? CW'(1) : sup.unlock_cnt_i;
  end

  always_comb begin
    state_d = state_q;
    run_d   = '0;
    sat_d   = '0;
    lost_d  = lost_q;
    if (!sup.enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_RESET;
        ST_RESET: begin
          if (reached(run_q, hold_n)) state_d = ST_ACQUIRE;
          else                        run_d   = sat_inc(run_q);
        end
        // Lock wins over abort when both terminal counts land on the same edge.
        ST_ACQUIRE: begin
          if (in_win && reached(run_q, lock_n)) begin
            state_d = ST_LOCKED;
          end else if (out_sat && reached(sat_q, unlock_n)) begin
            state_d = ST_RESET;
          end else begin
            run_d = in_win  ? sat_inc(run_q) : '0;
            sat_d = out_sat ? sat_inc(sat_q) : '0;
          end
        end
        ST_LOCKED: begin
          if (bad) begin
            if (reached(run_q, unlock_n)) begin
              state_d = sup.relock_i ? ST_RESET : ST_HOLD;
              lost_d  = (&lost_q) ? lost_q : lost_q + LW'(1);
            end else begin
              run_d = sat_inc(run_q);
            end
          end
        end
        ST_HOLD:  state_d = ST_HOLD;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      run_q   <= '0;
      sat_q   <= '0;
      lost_q  <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      sat_q   <= sat_d;
      lost_q  <= lost_d;
    end
  end

  // {int_rst, freeze, ifreeze, locked}
  always_comb begin
    case (state_q)
      ST_ACQUIRE: dec = 4'b0000;
      ST_LOCKED:  dec = 4'b0001;
      ST_HOLD:    dec = 4'b0110;
      default:    dec = 4'b1010;
    endcase
  end

  assign sup.int_rst_o     = dec[3];
  assign sup.pid_freeze_o  = dec[2];
  assign sup.pid_ifreeze_o = dec[1];
  assign sup.locked_o      = dec[0];
  assign sup.state_o       = state_q;
  assign sup.lost_cnt_o    = lost_q;

endmodule
